spi_packet_rx: RTL and testbench

//  Parametrised SPI slave receiver feeding the top-level control path. It

---
 rtl/spi_packet_rx_if.sv | 30 +++
 rtl/spi_packet_rx.sv | 152 +++++++++++++++
 tb/tb_spi_packet_rx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_packet_rx_if.sv
// Bundle between the SPI packet receiver and its environment: the serial pins
// coming in plus the committed-packet results and the channel register bank going out.
interface spi_packet_rx_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4
);
  // There is no ready/valid handshake. cs/sck/sdi are free-running asynchronous pins.
  // pkt_valid, frame_err and addr_err are single-cycle pulses, and exactly one pulses per frame.
  // pkt_addr, pkt_data and ch_data are level outputs that hold until the next good commit.
  logic                       cs;
  logic                       sck;
  logic                       sdi;
  logic                       pkt_valid;
  logic [ADDR_W-1:0]          pkt_addr;
  logic [DATA_W-1:0]          pkt_data;
  logic [NUM_CH*DATA_W-1:0]   ch_data;
  logic                       frame_err;
  logic                       addr_err;

  modport master (
    output cs, sck, sdi,
    input  pkt_valid, pkt_addr, pkt_data, ch_data, frame_err, addr_err
  );

  modport slave (
    input  cs, sck, sdi,
    output pkt_valid, pkt_addr, pkt_data, ch_data, frame_err, addr_err
  );
endinterface

// File: rtl/spi_packet_rx.sv
// SPI slave receiver: oversamples cs/sck/sdi and shifts in one ADDR_W+DATA_W packet,
// MSB first, per cs-high frame. It commits good packets into a NUM_CH-entry register bank.
module spi_packet_rx #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_packet_rx_if.slave    bus,
  output logic [1:0]        dbg_state
);
  localparam int PKT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(PKT_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PKT_W + 1);
  localparam logic [ADDR_W:0]  NUM_CH_X = (ADDR_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync;
  logic                   cs_s, sck_s, sdi_s;
  logic                   cs_s_d, sck_s_d;
  logic                   cs_rise, cs_fall, sck_rise;

  logic [PKT_W-1:0]       shreg;
  logic [CNT_W-1:0]       cnt;
  logic                   clr, shift_en, do_commit;

  logic                   pkt_valid_q, frame_err_q, addr_err_q;
  logic [ADDR_W-1:0]      pkt_addr_q;
  logic [DATA_W-1:0]      pkt_data_q;
  logic [NUM_CH*DATA_W-1:0] ch_q;

  logic [ADDR_W-1:0]      sh_addr;
  logic [DATA_W-1:0]      sh_data;
  logic                   addr_oob;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  // The *_d flops hold the synchronised value one clock earlier, for edge detection.
  // Because they reset to 0, a cs held high through reset release is seen as a rise.
  assign cs_rise  =  cs_s & ~cs_s_d;
  assign cs_fall  = ~cs_s &  cs_s_d;
  assign sck_rise =  sck_s & ~sck_s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync  <= '0;
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_s_d   <= 1'b0;
      sck_s_d  <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  bus.cs};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      cs_s_d   <= cs_s;
      sck_s_d  <= sck_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // An sck rise that coincides with cs_fall is dropped, because cs_s is already low.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    do_commit = 1'b0;
    case (state)
      IDLE: begin
        if (cs_rise) begin
          state_nxt = SHIFT;
          clr       = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_fall)       state_nxt = COMMIT;
        else if (sck_rise) shift_en  = 1'b1;
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sh_addr  = shreg[PKT_W-1 -: ADDR_W];
  assign sh_data  = shreg[DATA_W-1:0];
  assign addr_oob = {1'b0, sh_addr} >= NUM_CH_X;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      cnt         <= '0;
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      pkt_addr_q  <= '0;
      pkt_data_q  <= '0;
      ch_q        <= '0;
    end else begin
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      if (clr) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (shift_en) begin
        shreg <= {shreg[PKT_W-2:0], sdi_s};
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
      // The counter saturates at PKT_W+1, so any over-long frame still reads as a frame error.
      if (do_commit) begin
        if (cnt != CNT_FULL) begin
          frame_err_q <= 1'b1;
        end else if (addr_oob) begin
          addr_err_q <= 1'b1;
        end else begin
          pkt_valid_q <= 1'b1;
          pkt_addr_q  <= sh_addr;
          pkt_data_q  <= sh_data;
          for (int i = 0; i < NUM_CH; i++) begin
            if (sh_addr == ADDR_W'(i)) ch_q[i*DATA_W +: DATA_W] <= sh_data;
          end
        end
      end
    end
  end

  assign bus.pkt_valid = pkt_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.pkt_addr  = pkt_addr_q;
  assign bus.pkt_data  = pkt_data_q;
  assign bus.ch_data   = ch_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_spi_packet_rx.sv
// Bench for spi_packet_rx. Two instances (8/16/4 and 4/12/8) share the same serial pins,
// and each is compared every cycle against a frame-level model of its expected commits.
module tb_spi_packet_rx;
  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cs    = 1'b0;
  logic sck   = 1'b0;
  logic sdi   = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_packet_rx_if #(.ADDR_W(8), .DATA_W(16), .NUM_CH(4)) bus_a ();
  spi_packet_rx_if #(.ADDR_W(4), .DATA_W(12), .NUM_CH(8)) bus_b ();

  assign bus_a.cs  = cs;
  assign bus_a.sck = sck;
  assign bus_a.sdi = sdi;
  assign bus_b.cs  = cs;
  assign bus_b.sck = sck;
  assign bus_b.sdi = sdi;

  logic [1:0] dbg_a, dbg_b;

  spi_packet_rx #(.ADDR_W(8), .DATA_W(16), .NUM_CH(4), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .dbg_state(dbg_a));
  spi_packet_rx #(.ADDR_W(4), .DATA_W(12), .NUM_CH(8), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .dbg_state(dbg_b));

  // ---------------- scoreboard ----------------
  // Each entry is {pulse {valid,frame_err,addr_err}, addr, data}.
  logic [26:0] exp_a_q[$];
  logic [18:0] exp_b_q[$];
  logic [15:0] bank_a[4];
  logic [11:0] bank_b[8];
  logic [7:0]  last_addr_a;
  logic [15:0] last_data_a;
  logic [3:0]  last_addr_b;
  logic [11:0] last_data_b;
  int          last_fall_cyc = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_latency(input string name);
    int lat;
    lat = cyc - last_fall_cyc;
    checks++;
    if (lat < SYNC + 2 || lat > SYNC + 4) begin
      errors++;
      $display("FAIL %s: got %0d cycles expected %0d..%0d", name, lat, SYNC + 2, SYNC + 4);
    end
  endtask

  always @(negedge clk) begin : cmp_a
    logic [2:0]  p;
    logic [26:0] e;
    logic [63:0] flat;
    if (reset) begin
      for (int i = 0; i < 4; i++) bank_a[i] = '0;
      last_addr_a = '0;
      last_data_a = '0;
      exp_a_q.delete();
    end
    p = {bus_a.pkt_valid, bus_a.frame_err, bus_a.addr_err};
    if (p != 3'b000) begin
      check("a_onehot", 128'($countones(p)), 128'(1));
      if (exp_a_q.size() == 0) begin
        check("a_unexpected_pulse", 128'(p), 128'(0));
      end else begin
        e = exp_a_q.pop_front();
        check("a_pulse_kind", 128'(p), 128'(e[26:24]));
        check_latency("a_latency");
        if (e[26]) begin
          bank_a[e[17:16]] = e[15:0];
          last_addr_a = e[23:16];
          last_data_a = e[15:0];
        end
      end
    end
    for (int i = 0; i < 4; i++) flat[i*16 +: 16] = bank_a[i];
    check("a_ch_data", 128'(bus_a.ch_data), 128'(flat));
    check("a_pkt_addr", 128'(bus_a.pkt_addr), 128'(last_addr_a));
    check("a_pkt_data", 128'(bus_a.pkt_data), 128'(last_data_a));
    check("a_state_legal", 128'(dbg_a != 2'd3), 128'(1));
  end

  always @(negedge clk) begin : cmp_b
    logic [2:0]  p;
    logic [18:0] e;
    logic [95:0] flat;
    if (reset) begin
      for (int i = 0; i < 8; i++) bank_b[i] = '0;
      last_addr_b = '0;
      last_data_b = '0;
      exp_b_q.delete();
    end
    p = {bus_b.pkt_valid, bus_b.frame_err, bus_b.addr_err};
    if (p != 3'b000) begin
      check("b_onehot", 128'($countones(p)), 128'(1));
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_pulse", 128'(p), 128'(0));
      end else begin
        e = exp_b_q.pop_front();
        check("b_pulse_kind", 128'(p), 128'(e[18:16]));
        check_latency("b_latency");
        if (e[18]) begin
          bank_b[e[14:12]] = e[11:0];
          last_addr_b = e[15:12];
          last_data_b = e[11:0];
        end
      end
    end
    for (int i = 0; i < 8; i++) flat[i*12 +: 12] = bank_b[i];
    check("b_ch_data", 128'(bus_b.ch_data), 128'(flat));
    check("b_pkt_addr", 128'(bus_b.pkt_addr), 128'(last_addr_b));
    check("b_pkt_data", 128'(bus_b.pkt_data), 128'(last_data_b));
    check("b_state_legal", 128'(dbg_b != 2'd3), 128'(1));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] v, input int nbits, input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = v[i];
      wait_clk(half);
      sck = 1'b1;
      wait_clk(half);
      sck = 1'b0;
    end
  endtask

  // Frame-level rule: a frame of the wrong length is a frame error; otherwise the top bits
  // are the address, and an address of NUM_CH or more is an address error.
  task automatic expect_frame(input logic [31:0] v, input int nbits);
    if (nbits != 24)            exp_a_q.push_back({3'b010, 24'h0});
    else if (v[23:16] >= 8'd4)  exp_a_q.push_back({3'b001, v[23:0]});
    else                        exp_a_q.push_back({3'b100, v[23:0]});
    if (nbits != 16)            exp_b_q.push_back({3'b010, 16'h0});
    else if (v[15:12] >= 4'd8)  exp_b_q.push_back({3'b001, v[15:0]});
    else                        exp_b_q.push_back({3'b100, v[15:0]});
  endtask

  task automatic close_frame(input logic [31:0] v, input int nbits, input int half);
    int n;
    wait_clk(half);
    cs = 1'b0;
    last_fall_cyc = cyc;
    expect_frame(v, nbits);
    n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 30) begin
      wait_clk(1);
      n++;
    end
    check("result_pulse_seen", 128'(exp_a_q.size() + exp_b_q.size()), 128'(0));
    exp_a_q.delete();
    exp_b_q.delete();
    wait_clk(half + 2);
  endtask

  task automatic send_frame(input logic [31:0] v, input int nbits, input int half);
    cs = 1'b1;
    wait_clk(half);
    shift_bits(v, nbits, half);
    close_frame(v, nbits, half);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] v;
    int          nbits, r, half;

    reset = 1'b1;
    wait_clk(4);
    check("reset_ch_a", 128'(bus_a.ch_data), 128'(0));
    check("reset_pulses_a", 128'({bus_a.pkt_valid, bus_a.frame_err, bus_a.addr_err}), 128'(0));
    check("reset_state_a", 128'(dbg_a), 128'(0));
    reset = 1'b0;
    wait_clk(4);

    send_frame(32'h0114FF, 24, 4);
    check("t1_ch_a", 128'(bus_a.ch_data), 128'(64'h0000_0000_14FF_0000));
    check("t1_addr_a", 128'(bus_a.pkt_addr), 128'(8'h01));
    check("t1_data_a", 128'(bus_a.pkt_data), 128'(16'h14FF));

    send_frame(32'h00AAAA, 24, 3);
    send_frame(32'h035555, 24, 5);
    check("t2_ch_a", 128'(bus_a.ch_data), 128'(64'h5555_0000_14FF_AAAA));
    check("t2_addr_a", 128'(bus_a.pkt_addr), 128'(8'h03));

    send_frame(32'h07BEEF, 24, 4);
    check("t3_ch_a", 128'(bus_a.ch_data), 128'(64'h5555_0000_14FF_AAAA));
    check("t3_addr_a", 128'(bus_a.pkt_addr), 128'(8'h03));
    check("t3_data_a", 128'(bus_a.pkt_data), 128'(16'h5555));

    send_frame(32'h012222, 23, 4);
    send_frame(32'h1012222, 25, 4);
    check("t4_ch_a_held", 128'(bus_a.ch_data), 128'(64'h5555_0000_14FF_AAAA));
    send_frame(32'h023333, 24, 4);
    check("t4_ch_a", 128'(bus_a.ch_data), 128'(64'h5555_3333_14FF_AAAA));

    // Reset in the middle of a frame: nothing is committed and the bank clears.
    cs = 1'b1;
    wait_clk(4);
    shift_bits(32'h02CAFE >> 12, 12, 4);
    wait_clk(2);
    reset = 1'b1;
    wait_clk(3);
    cs = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(6);
    check("t5_ch_a_cleared", 128'(bus_a.ch_data), 128'(0));
    check("t5_addr_a_cleared", 128'(bus_a.pkt_addr), 128'(0));
    send_frame(32'h02CAFE, 24, 4);
    check("t5_ch2_a", 128'(bus_a.ch_data[47:32]), 128'(16'hCAFE));

    send_frame(32'h7ABC, 16, 4);
    check("t6_ch7_b", 128'(bus_b.ch_data[95:84]), 128'(12'hABC));
    check("t6_ch_a_held", 128'(bus_a.ch_data), 128'(64'h0000_CAFE_0000_0000));

    // cs held high through reset release opens a frame.
    cs = 1'b1;
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(6);
    shift_bits(32'h021234, 24, 4);
    close_frame(32'h021234, 24, 4);
    check("t7_ch2_a", 128'(bus_a.ch_data[47:32]), 128'(16'h1234));

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       nbits = 24;
      else if (r < 7)  nbits = 16;
      else if (r == 7) nbits = 23;
      else if (r == 8) nbits = 25;
      else             nbits = 15;
      v = $urandom;
      if (nbits == 24) v[23:16] = 8'($urandom_range(0, 5));
      half = $urandom_range(3, 5);
      send_frame(v, nbits, half);
    end

    wait_clk(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
